// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions used by the integer register file and its
// scoreboard: default register width, register count and the x0 constant.
package rv_pkg;

    // Default integer register width (RV32).
    localparam int RV_XLEN = 32;

    // Default architectural register count.
    localparam int RV_NREG = 32;

    // Architectural zero register index; hardwired to zero, never pending.
    localparam int REG_ZERO = 0;

    // Register address for the default 32-entry file.
    typedef logic [$clog2(RV_NREG)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Destination scoreboard: one pending bit per register, set when a producer
// issues and cleared at its writeback, plus an NRD-port busy lookup that
// masks a register being written this cycle when write-through is enabled.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter int NREG   = RV_NREG,
    parameter int NRD    = 2,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [NREG-1:0] r_pend;
    logic            w_clr;
    logic            w_set;

    // x0 can never be written or become pending, so both strobes exclude it.
    assign w_clr = wr_en  && (wr_addr  != ZERO_ADDR);
    assign w_set = iss_en && (iss_addr != ZERO_ADDR);

    // Pending bits: reset drops all outstanding producers; an issue to the
    // register being written in the same cycle wins, since that issuer is
    // the younger instruction and its result is still outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            if (w_clr) begin
                r_pend[wr_addr] <= 1'b0;
            end
            if (w_set) begin
                r_pend[iss_addr] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_busy
        logic [AW-1:0] w_ra;
        logic          w_fwd;

        assign w_ra  = rd_addr[g*AW +: AW];
        // A writeback landing this cycle resolves the hazard only if its data
        // is forwarded to the reader; otherwise the reader must wait a cycle.
        assign w_fwd = (BYPASS != 0) && wr_en && (wr_addr == w_ra);

        // Busy lookup; the issue strobe is deliberately absent so a decoding
        // instruction never stalls on its own destination.
        always_comb begin
            rd_busy[g] = 1'b0;
            if (!rst && (w_ra != ZERO_ADDR) && !w_fwd) begin
                rd_busy[g] = r_pend[w_ra];
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised integer register file for the decode stage: NREG x XLEN
// storage, NRD combinational read ports with optional write-through bypass,
// and a destination scoreboard reporting per-port busy to the hazard unit.
module reg_file_sb
    import rv_pkg::*;
#(
    parameter int XLEN   = RV_XLEN,
    parameter int NREG   = RV_NREG,
    parameter int NRD    = 2,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [XLEN-1:0] r_mem [NREG];
    logic            w_wr_ok;

    // Writes to x0 are discarded so entry 0 always holds zero in storage too.
    assign w_wr_ok = wr_en && (wr_addr != ZERO_ADDR);

    // Register storage: reset clears every entry; writeback updates one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] w_ra;

        assign w_ra = rd_addr[g*AW +: AW];

        // Read mux: reset and x0 read as zero, then same-cycle writeback
        // forwarding, then storage.
        always_comb begin
            rd_data[g*XLEN +: XLEN] = r_mem[w_ra];
            if (rst || (w_ra == ZERO_ADDR)) begin
                rd_data[g*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && wr_en && (wr_addr == w_ra)) begin
                rd_data[g*XLEN +: XLEN] = wr_data;
            end
        end
    end

    reg_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two default-size files (bypass on and off) share
// one stimulus stream; a 16x64, three-port file gets its own random traffic.
// Expected reads come from an array/flag model of the architectural state.
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, wr_en, iss_en;

    // 32 x 32, two ports, instances A (bypass) and B (no bypass)
    logic [9:0]  ab_rd_addr;
    logic [4:0]  ab_wr_addr, ab_iss_addr;
    logic [31:0] ab_wr_data;
    logic [63:0] a_rd_data, b_rd_data;
    logic [1:0]  a_rd_busy, b_rd_busy;

    // 16 x 64, three ports, instance C
    logic [11:0]  c_rd_addr;
    logic [3:0]   c_wr_addr, c_iss_addr;
    logic [63:0]  c_wr_data;
    logic [191:0] c_rd_data;
    logic [2:0]   c_rd_busy;

    reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(ab_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(wr_en), .wr_addr(ab_wr_addr),
        .wr_data(ab_wr_data), .iss_en(iss_en), .iss_addr(ab_iss_addr));

    reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(ab_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(ab_wr_addr),
        .wr_data(ab_wr_data), .iss_en(iss_en), .iss_addr(ab_iss_addr));

    reg_file_sb #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .wr_en(wr_en), .wr_addr(c_wr_addr),
        .wr_data(c_wr_data), .iss_en(iss_en), .iss_addr(c_iss_addr));

    typedef struct packed {
        bit              is_c;
        logic [1:0][31:0] da;
        logic [1:0][31:0] db;
        logic [1:0]       ba;
        logic [1:0]       bb;
        logic [2:0][63:0] dc;
        logic [2:0]       bc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Architectural model: register values and outstanding-producer flags.
    logic [63:0] m_mem  [32];
    bit          m_pend [32];

    function automatic logic [63:0] m_data(int a, bit byp, bit r, bit we, int wa, logic [63:0] wd);
        if (r || a == 0) return 64'd0;
        if (byp && we && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic bit m_busy(int a, bit byp, bit r, bit we, int wa);
        if (r || a == 0) return 1'b0;
        if (byp && we && wa == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic void m_commit(bit r, bit we, int wa, logic [63:0] wd, bit ie, int ia);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 64'd0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) begin
                m_mem[wa]  = wd;
                m_pend[wa] = 1'b0;
            end
            if (ie && ia != 0) m_pend[ia] = 1'b1;
        end
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // One cycle on the 32x32 pair: drive, predict, then commit at the edge.
    task automatic cyc_ab(input bit r, input int a0, input int a1, input bit we, input int wa,
                          input logic [31:0] wd, input bit ie, input int ia);
        exp_t e;
        int   ad[2];
        ad[0] = a0;
        ad[1] = a1;
        rst = r; wr_en = we; iss_en = ie;
        ab_rd_addr  = {5'(a1), 5'(a0)};
        ab_wr_addr  = 5'(wa);
        ab_wr_data  = wd;
        ab_iss_addr = 5'(ia);
        e = '0;
        e.is_c = 1'b0;
        for (int p = 0; p < 2; p++) begin
            e.da[p] = 32'(m_data(ad[p], 1'b1, r, we, wa, {32'd0, wd}));
            e.db[p] = 32'(m_data(ad[p], 1'b0, r, we, wa, {32'd0, wd}));
            e.ba[p] = m_busy(ad[p], 1'b1, r, we, wa);
            e.bb[p] = m_busy(ad[p], 1'b0, r, we, wa);
        end
        q.push_back(e);
        @(posedge clk);
        m_commit(r, we, wa, {32'd0, wd}, ie, ia);
        #1;
    endtask

    // One cycle on the 16x64 three-port file.
    task automatic cyc_c(input bit r, input int a0, input int a1, input int a2, input bit we,
                         input int wa, input logic [63:0] wd, input bit ie, input int ia);
        exp_t e;
        int   ad[3];
        ad[0] = a0;
        ad[1] = a1;
        ad[2] = a2;
        rst = r; wr_en = we; iss_en = ie;
        c_rd_addr  = {4'(a2), 4'(a1), 4'(a0)};
        c_wr_addr  = 4'(wa);
        c_wr_data  = wd;
        c_iss_addr = 4'(ia);
        e = '0;
        e.is_c = 1'b1;
        for (int p = 0; p < 3; p++) begin
            e.dc[p] = m_data(ad[p], 1'b1, r, we, wa, wd);
            e.bc[p] = m_busy(ad[p], 1'b1, r, we, wa);
        end
        q.push_back(e);
        @(posedge clk);
        m_commit(r, we, wa, wd, ie, ia);
        #1;
    endtask

    task automatic rand_ab();
        int wa, ia, a0, a1;
        bit r, we, ie;
        wa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        ia = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
        a0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
        a1 = ($urandom_range(0, 3) == 0) ? a0 : (($urandom_range(0, 1) == 0) ? ia : $urandom_range(0, 7));
        r  = ($urandom_range(0, 59) == 0);
        we = $urandom_range(0, 1);
        ie = $urandom_range(0, 1);
        cyc_ab(r, a0, a1, we, wa, $urandom, ie, ia);
    endtask

    task automatic rand_c();
        int wa, ia, a0, a1, a2;
        bit r, we, ie;
        wa = $urandom_range(0, 15);
        ia = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
        a0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) begin
            a1 = a0;
            a2 = a0;
        end else begin
            a1 = ($urandom_range(0, 1) == 0) ? ia : $urandom_range(0, 15);
            a2 = $urandom_range(0, 15);
        end
        r  = ($urandom_range(0, 59) == 0);
        we = $urandom_range(0, 1);
        ie = $urandom_range(0, 1);
        cyc_c(r, a0, a1, a2, we, wa, {$urandom, $urandom}, ie, ia);
    endtask

    // Monitor: the read path is combinational, so every queued prediction is
    // checked mid-cycle, away from the edge that commits the state change.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            me = q.pop_front();
            if (!me.is_c) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("A_data[%0d]", p), {32'd0, a_rd_data[p*32 +: 32]}, {32'd0, me.da[p]});
                    chk($sformatf("A_busy[%0d]", p), {63'd0, a_rd_busy[p]}, {63'd0, me.ba[p]});
                    chk($sformatf("B_data[%0d]", p), {32'd0, b_rd_data[p*32 +: 32]}, {32'd0, me.db[p]});
                    chk($sformatf("B_busy[%0d]", p), {63'd0, b_rd_busy[p]}, {63'd0, me.bb[p]});
                end
            end else begin
                for (int p = 0; p < 3; p++) begin
                    chk($sformatf("C_data[%0d]", p), c_rd_data[p*64 +: 64], me.dc[p]);
                    chk($sformatf("C_busy[%0d]", p), {63'd0, c_rd_busy[p]}, {63'd0, me.bc[p]});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; iss_en = 1'b0;
        ab_rd_addr = '0; ab_wr_addr = '0; ab_wr_data = '0; ab_iss_addr = '0;
        c_rd_addr = '0; c_wr_addr = '0; c_wr_data = '0; c_iss_addr = '0;
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 64'd0;
            m_pend[i] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Reset for two cycles with write/issue traffic that must be dropped.
        cyc_ab(1'b1, 3, 3, 1'b1, 3, 32'h1111_1111, 1'b1, 3);
        cyc_ab(1'b1, 4, 3, 1'b1, 4, 32'h2222_2222, 1'b1, 4);
        for (int i = 0; i < 32; i++) cyc_ab(1'b0, i, 31 - i, 1'b0, 0, 32'd0, 1'b0, 0);

        // x0 ignores writes and issues.
        cyc_ab(1'b0, 0, 0, 1'b1, 0, 32'hDEAD_BEEF, 1'b1, 0);
        cyc_ab(1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0, 0);

        // Bypass vs storage-only on x5, with x5 already pending.
        cyc_ab(1'b0, 5, 5, 1'b1, 5, 32'hAAAA_0005, 1'b1, 5);
        cyc_ab(1'b0, 5, 5, 1'b1, 5, 32'h1234_5678, 1'b0, 0);
        cyc_ab(1'b0, 0, 5, 1'b0, 0, 32'd0, 1'b0, 0);

        // Scoreboard lifetime on x7: issue, three waiting cycles, writeback.
        cyc_ab(1'b0, 7, 7, 1'b0, 0, 32'd0, 1'b1, 7);
        for (int i = 0; i < 3; i++) cyc_ab(1'b0, 7, 7, 1'b0, 0, 32'd0, 1'b0, 0);
        cyc_ab(1'b0, 7, 7, 1'b1, 7, 32'h0000_00A5, 1'b0, 0);
        cyc_ab(1'b0, 7, 7, 1'b0, 0, 32'd0, 1'b0, 0);

        // Simultaneous issue and write on x9, then reset mid-flight.
        cyc_ab(1'b0, 9, 9, 1'b1, 9, 32'h0909_0909, 1'b1, 9);
        cyc_ab(1'b0, 9, 9, 1'b0, 0, 32'd0, 1'b0, 0);
        cyc_ab(1'b1, 9, 9, 1'b0, 0, 32'd0, 1'b0, 0);
        cyc_ab(1'b0, 9, 7, 1'b0, 0, 32'd0, 1'b0, 0);

        for (int i = 0; i < 400; i++) rand_ab();

        // Wide, three-port configuration.
        cyc_c(1'b1, 0, 0, 0, 1'b0, 0, 64'd0, 1'b0, 0);
        cyc_c(1'b1, 1, 2, 3, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
        for (int i = 0; i < 16; i++) cyc_c(1'b0, i, 15 - i, i, 1'b0, 0, 64'd0, 1'b0, 0);
        cyc_c(1'b0, 6, 6, 6, 1'b0, 0, 64'd0, 1'b1, 6);
        cyc_c(1'b0, 6, 6, 6, 1'b0, 0, 64'd0, 1'b0, 0);
        cyc_c(1'b0, 6, 6, 6, 1'b1, 6, 64'hFEDC_BA98_7654_3210, 1'b0, 0);
        cyc_c(1'b0, 6, 6, 6, 1'b0, 0, 64'd0, 1'b0, 0);
        for (int i = 0; i < 600; i++) rand_c();

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with a built-in destination scoreboard and write-through bypass, replacing the fixed 2-read/1-write 32x32 file in the decode stage of the 5-stage RISC-V pipeline. It holds NREG registers of XLEN bits and serves NRD combinational read ports. It tracks a pending bit per register from issue (decode) to writeback, so the hazard unit can stall on an unresolved producer. Register 0 is hardwired to zero and is never pending.

## Interface
- XLEN, 32: register width in bits
- NREG, 32: number of registers, power of two, at least 2
- NRD, 2: number of read ports, at least 1
- AW, $clog2(NREG): address width (derived, not overridden)
- BYPASS, 1: 1 = same-cycle write forwards to reads; 0 = reads see storage only
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i's addressed register has an outstanding producer
- wr_en  in  1  writeback enable
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- iss_en  in  1  an instruction with a destination issues this cycle
- iss_addr  in  AW  destination of the issuing instruction

## Operation
- Storage: NREG x XLEN array plus NREG pending bits. Entry 0 reads 0 and ignores writes and issues.
- Write: at posedge, if wr_en, !rst and wr_addr != 0, then mem[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Issue: at posedge, if iss_en, !rst and iss_addr != 0, then pending[iss_addr] <= 1.
- Same register written and issued in one cycle: the issue wins and pending ends at 1, because the issuer is younger.
- Read data for port i, evaluated combinationally in this priority order:
  - rst high gives 0.
  - rd_addr == 0 gives 0.
  - BYPASS and wr_en and wr_addr == rd_addr gives wr_data.
  - Otherwise mem[rd_addr].
- Busy for port i:
  - pending[rd_addr], and rd_addr != 0, and not (wr_en and wr_addr == rd_addr and BYPASS).
  - Forced to 0 while rst is high.
  - With BYPASS=0, a register being written this cycle still reports busy.
- iss_en in cycle N never affects rd_busy in cycle N. The decode instruction reads its own sources before its destination becomes pending.
- Reset: a posedge with rst=1 clears every mem entry to 0 and every pending bit to 0. Writes and issues in that cycle are dropped. Reset asserted mid-operation discards all outstanding pending state.
- Multiple read ports may address the same register; each gets identical data and busy.

## Timing
- Read path is combinational: zero-cycle latency from rd_addr, wr_* and pending to rd_data and rd_busy.
- Write and issue take effect at the next posedge; storage readback without bypass is visible from cycle N+1.
- Pending set by issue in cycle N reports busy from cycle N+1 until the writeback cycle inclusive. With BYPASS=1, busy drops in the writeback cycle itself.
- Reset values:
  - All rd_data = 0 and rd_busy = 0 while rst is high.
  - After release, storage reads 0 and nothing is busy.
- No handshake or backpressure. The caller guarantees at most one in-flight producer per register (in-order pipeline).

## Structure
- Shared package rv_pkg: XLEN default, REG_ZERO constant (0), and the reg_addr_t typedef for the default 32-register address.
- Sub-module reg_scoreboard: the NREG pending bits with issue/clear/reset logic and an NRD-port busy lookup, including the bypass mask.
- Top level: storage array, read multiplexers with bypass, and the scoreboard instance.

## Test plan
- Reset then read all: assert rst 2 cycles, release, sweep rd_addr 0..31 on both ports -> rd_data = 0 and rd_busy = 0 everywhere.
- x0 protection: wr_en=1, wr_addr=0, wr_data=0xDEADBEEF, plus iss_en to 0 -> read x0 gives 0 and not busy, both same cycle and next.
- Bypass: write x5 = 0x12345678 while port 1 reads x5 in the same cycle -> 0x12345678 with busy 0 when BYPASS=1. With BYPASS=0 -> old value and busy 1 that cycle, new value and busy 0 the next.
- Scoreboard: issue x7 at cycle 1 -> rd_busy for x7 is 0 at cycle 1 and 1 at cycles 2..4. Write x7 = 0xA5 at cycle 5 -> busy 0 at cycle 5 (bypass) and at cycle 6.
- Simultaneous issue and write to x9 -> data updated, x9 remains busy next cycle. Then rst mid-flight -> all busy cleared and x9 reads 0.
- Parameter sweep: NREG=16, NRD=3, XLEN=64, random write/issue/read traffic checked against a reference model, including all three ports addressing the same register.
